// File: rtl/madd_eval_pkg.sv
// Shared types and width helpers for the approximate multiply-add error sweep.
package madd_eval_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_e;

    localparam int DEF_IN_W  = 18;
    localparam int DEF_OUT_W = 12;

    // One extra bit so a sweep where every vector mismatches still fits.
    function automatic int cnt_w(input int in_w);
        return in_w + 1;
    endfunction

    function automatic int sum_w(input int in_w, input int out_w);
        return in_w + out_w;
    endfunction

endpackage

// File: rtl/madd_err_accum.sv
// Stage-2 absolute-difference and error metric accumulators (count, sum, max, max vector).
module madd_err_accum
    import madd_eval_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int CNT_W = cnt_w(IN_W),
    parameter int SUM_W = sum_w(IN_W, OUT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             valid_i,
    input  logic [OUT_W-1:0] exact_i,
    input  logic [OUT_W-1:0] approx_i,
    input  logic [IN_W-1:0]  vec_i,
    output logic [CNT_W-1:0] err_count_o,
    output logic [SUM_W-1:0] err_sum_o,
    output logic [OUT_W-1:0] err_max_o,
    output logic [IN_W-1:0]  max_vec_o
);

    logic [OUT_W-1:0] diff_s;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [OUT_W-1:0] max_q, max_d;
    logic [IN_W-1:0]  max_vec_q, max_vec_d;

    always_comb begin
        diff_s    = (exact_i >= approx_i) ? (exact_i - approx_i) : (approx_i - exact_i);
        count_d   = count_q;
        sum_d     = sum_q;
        max_d     = max_q;
        max_vec_d = max_vec_q;
        if (clr_i) begin
            count_d   = '0;
            sum_d     = '0;
            max_d     = '0;
            max_vec_d = '0;
        end else if (valid_i) begin
            count_d = count_q + CNT_W'(diff_s != '0);
            sum_d   = sum_q + SUM_W'(diff_s);
            // Strictly greater, so ties keep the earlier vector.
            if (diff_s > max_q) begin
                max_d     = diff_s;
                max_vec_d = vec_i;
            end else begin
                max_d     = max_q;
                max_vec_d = max_vec_q;
            end
        end else begin
            count_d = count_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            sum_q     <= '0;
            max_q     <= '0;
            max_vec_q <= '0;
        end else begin
            count_q   <= count_d;
            sum_q     <= sum_d;
            max_q     <= max_d;
            max_vec_q <= max_vec_d;
        end
    end

    assign err_count_o = count_q;
    assign err_sum_o   = sum_q;
    assign err_max_o   = max_q;
    assign max_vec_o   = max_vec_q;

endmodule

// File: rtl/madd_err_sweep_ctrl.sv
// Sweep controller: FSM, input vector counter and stage-1 capture of both circuit outputs.
module madd_err_sweep_ctrl
    import madd_eval_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int CNT_W = cnt_w(IN_W),
    parameter int SUM_W = sum_w(IN_W, OUT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [IN_W-1:0]  vec_o,
    output logic             vec_valid_o,
    input  logic [OUT_W-1:0] exact_i,
    input  logic [OUT_W-1:0] approx_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [SUM_W-1:0] err_sum_o,
    output logic [OUT_W-1:0] err_max_o,
    output logic [IN_W-1:0]  max_vec_o
);

    localparam logic [IN_W-1:0] VEC_LAST = {IN_W{1'b1}};

    sweep_state_e     state_q;
    logic [IN_W-1:0]  vec_q;
    logic             vld_q;
    logic             busy_q;
    logic             done_q;
    logic             drain_q;
    logic [OUT_W-1:0] s1_exact_q;
    logic [OUT_W-1:0] s1_approx_q;
    logic [IN_W-1:0]  s1_vec_q;
    logic             s1_vld_q;
    logic             acc_clr_s;
    logic             acc_vld_s;

    assign acc_clr_s = start && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // Abort freezes the accumulators on the same edge it takes effect.
    assign acc_vld_s = s1_vld_q && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vec_q       <= '0;
            vld_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            drain_q     <= 1'b0;
            s1_exact_q  <= '0;
            s1_approx_q <= '0;
            s1_vec_q    <= '0;
            s1_vld_q    <= 1'b0;
        end else begin
            s1_exact_q  <= exact_i;
            s1_approx_q <= approx_i;
            s1_vec_q    <= vec_q;
            s1_vld_q    <= vld_q && !abort;
            if (abort) begin
                state_q <= ST_IDLE;
                vld_q   <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            state_q <= ST_SWEEP;
                            vec_q   <= '0;
                            vld_q   <= 1'b1;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                    ST_SWEEP: begin
                        // Last vector has been issued; hold it rather than wrap.
                        if (vec_q == VEC_LAST) begin
                            state_q <= ST_DRAIN;
                            vld_q   <= 1'b0;
                            drain_q <= 1'b0;
                        end else begin
                            vec_q <= vec_q + IN_W'(1);
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_q) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            drain_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        vld_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    madd_err_accum #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .CNT_W (CNT_W),
        .SUM_W (SUM_W)
    ) u_accum (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (acc_clr_s),
        .valid_i     (acc_vld_s),
        .exact_i     (s1_exact_q),
        .approx_i    (s1_approx_q),
        .vec_i       (s1_vec_q),
        .err_count_o (err_count_o),
        .err_sum_o   (err_sum_o),
        .err_max_o   (err_max_o),
        .max_vec_o   (max_vec_o)
    );

    assign vec_o       = vec_q;
    assign vec_valid_o = vld_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_madd_err_sweep_ctrl.sv
// Directed bench for madd_err_sweep_ctrl with a 4-bit input / 3-bit output circuit pair.
module tb_madd_err_sweep_ctrl;

    localparam int IN_W  = 4;
    localparam int OUT_W = 3;
    localparam int CNT_W = IN_W + 1;
    localparam int SUM_W = IN_W + OUT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [IN_W-1:0]  vec_o;
    logic             vec_valid_o;
    logic [OUT_W-1:0] exact_i;
    logic [OUT_W-1:0] approx_i;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] err_count_o;
    logic [SUM_W-1:0] err_sum_o;
    logic [OUT_W-1:0] err_max_o;
    logic [IN_W-1:0]  max_vec_o;

    int mode;
    int checks = 0;
    int errors = 0;

    madd_err_sweep_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .vec_o       (vec_o),
        .vec_valid_o (vec_valid_o),
        .exact_i     (exact_i),
        .approx_i    (approx_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_count_o (err_count_o),
        .err_sum_o   (err_sum_o),
        .err_max_o   (err_max_o),
        .max_vec_o   (max_vec_o)
    );

    always #5 clk = ~clk;

    // Stand-in combinational exact/approx circuits selected by mode.
    always_comb begin
        exact_i  = vec_o[2:0];
        approx_i = vec_o[2:0];
        case (mode)
            1: begin exact_i = vec_o[2:0]; approx_i = 3'd0; end
            2: begin exact_i = 3'd0;       approx_i = 3'd7; end
            3: begin exact_i = vec_o[2:0]; approx_i = {vec_o[0], vec_o[3:2]}; end
            default: begin exact_i = vec_o[2:0]; approx_i = vec_o[2:0]; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start, optionally re-pulses it mid-sweep, and returns cycles until done_o.
    task automatic run_sweep(input bit inject, output int cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_vec", 32'(vec_o), 32'd0);
        check("start_valid", 32'(vec_valid_o), 32'd1);
        check("start_clr", 32'(err_count_o), 32'd0);
        cyc = 0;
        while (!done_o && cyc < 100) begin
            start = (inject && cyc == 3) ? 1'b1 : 1'b0;
            tick();
            cyc++;
        end
        start = 1'b0;
        check("done_latency", 32'(cyc), 32'(2 ** IN_W + 2));
    endtask

    task automatic check_result(input string tag, input int c, input int s, input int m, input int mv);
        check({tag, "_count"}, 32'(err_count_o), 32'(c));
        check({tag, "_sum"}, 32'(err_sum_o), 32'(s));
        check({tag, "_max"}, 32'(err_max_o), 32'(m));
        check({tag, "_maxvec"}, 32'(max_vec_o), 32'(mv));
    endtask

    int cyc;
    int ec, es, em, emv;
    int d, ex, ap;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mode  = 0;
        #12;
        check("rst_valid", 32'(vec_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_count", 32'(err_count_o), 32'd0);
        rst = 1'b0;
        tick();

        // Identical circuits, with a stray start during the sweep.
        mode = 0;
        run_sweep(1'b1, cyc);
        check_result("exact_eq", 0, 0, 0, 0);
        check("done_valid", 32'(vec_valid_o), 32'd0);
        check("done_busy", 32'(busy_o), 32'd0);
        check("done_vec_held", 32'(vec_o), 32'd15);

        // approx = 0: diffs 0..7,0..7; max 7 first at vector 7.
        mode = 1;
        run_sweep(1'b0, cyc);
        check_result("approx0", 14, 56, 7, 7);
        repeat (3) tick();
        check("done_stable", 32'(done_o), 32'd1);
        check_result("approx0_hold", 14, 56, 7, 7);

        // Every vector off by the maximum; count reaches 2^IN_W.
        mode = 2;
        run_sweep(1'b0, cyc);
        check_result("full_err", 16, 112, 7, 0);

        // Mixed-sign differences, expected values from a behavioural loop.
        mode = 3;
        ec = 0; es = 0; em = 0; emv = 0;
        for (int v = 0; v < 16; v++) begin
            ex = v % 8;
            ap = ((v % 2) * 4) + (v / 4);
            d  = (ex > ap) ? ex - ap : ap - ex;
            if (d != 0) ec++;
            es += d;
            if (d > em) begin em = d; emv = v; end
        end
        run_sweep(1'b0, cyc);
        check_result("mixed", ec, es, em, emv);

        // Abort at vector 5: vectors 0..3 have reached the accumulators.
        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (vec_o != 4'd5 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("abort_reach5", 32'(vec_o), 32'd5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", 32'(vec_valid_o), 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        check_result("abort_part", 3, 6, 3, 3);
        repeat (4) tick();
        check_result("abort_frozen", 3, 6, 3, 3);

        // abort beats start.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_wins_busy", 32'(busy_o), 32'd0);
        check("abort_wins_valid", 32'(vec_valid_o), 32'd0);

        // Back-to-back sweeps from DONE give identical results.
        run_sweep(1'b0, cyc);
        check_result("rerun1", 14, 56, 7, 7);
        run_sweep(1'b0, cyc);
        check_result("rerun2", 14, 56, 7, 7);

        // Asynchronous reset mid-sweep.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_vec", 32'(vec_o), 32'd0);
        check("arst_valid", 32'(vec_valid_o), 32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        check_result("arst", 0, 0, 0, 0);
        rst = 1'b0;
        repeat (3) tick();
        check("arst_idle", 32'(busy_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
